qam_demap_flow_ctrl: RTL
========================

QAM_DEMAP_FLOW_CTRL -- requirements
Module: qam_demap_flow_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of one demapped symbol word.
REQ-002 SHALL have parameter DEPTH, default 16: FIFO depth in words, a power of 2 and at least 4.
REQ-003 SHALL have parameter THRESH, default DEPTH: fill level that raises available, in range 1..DEPTH.
REQ-004 SHALL have parameter OVF_W, default 8: width of the overflow counter.
REQ-005 SHALL have port dclk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: block enable.
REQ-008 SHALL have port flush, input, 1 bit: synchronous clear of FIFO contents and overflow_cnt.
REQ-009 SHALL have port mode, input, 1 bit: 0 = DROP (input discarded in READY), 1 = STREAM (input accepted in READY and READOUT).
REQ-010 SHALL have port in_valid, input, 1 bit: demapper symbol strobe.
REQ-011 SHALL have port in_data, input, DATA_W: demapper symbol.
REQ-012 SHALL have port read, input, 1 bit: host read request.
REQ-013 SHALL have port rd_data, output, DATA_W: popped word, registered.
REQ-014 SHALL have port rd_valid, output, 1 bit: rd_data valid strobe.
REQ-015 SHALL have port available, output, 1 bit: host data-available flag.
REQ-016 SHALL have port complete, output, 1 bit: host complete flag.
REQ-017 SHALL have port fill_level, output, clog2(DEPTH)+1: current word count.
REQ-018 SHALL have port overflow_cnt, output, OVF_W: count of discarded symbols.
REQ-019 SHALL have port state, output, 2 bits: current FSM state.

Function
REQ-020 FSM states SHALL be IDLE=00, RECEIVE=01, READY=10, READOUT=11; state is registered, and available/complete are decoded from state only (Moore).
REQ-021 IDLE: no push, no pop; complete=1, available=0; enable=1 goes to RECEIVE next cycle.
REQ-022 RECEIVE: push allowed; complete=1, available=0; fill_level>=THRESH goes to READY.
REQ-023 READY: available=1, complete=0; push allowed only when mode=1; read=1 goes to READOUT.
REQ-024 READOUT: available=1, complete=0; push allowed only when mode=1; pop on each cycle with read=1.
REQ-025 READOUT: fill_level==0 with no push that cycle goes to RECEIVE; read=0 holds the state.
REQ-026 enable=0 in any state SHALL force IDLE next cycle; FIFO contents are retained.
REQ-027 Push: in_valid & push-allowed & (not full, or pop in same cycle) writes in_data; otherwise the symbol is discarded.
REQ-028 Pop: read & state==READOUT & not empty; rd_data and rd_valid update on the following edge (latency 1); pop when empty is ignored and rd_valid=0.
REQ-029 Simultaneous push and pop SHALL leave fill_level unchanged, including at full; pointers wrap modulo DEPTH.
REQ-030 overflow_cnt SHALL increment on every discarded in_valid while state!=IDLE, saturating at all-ones with no wrap.
REQ-031 flush SHALL take priority over push and pop: pointers, fill_level and overflow_cnt go to 0, rd_valid goes to 0, and the FSM goes to IDLE if enable=0, else RECEIVE.
REQ-032 Reset asserted mid-operation SHALL abort any readout immediately; no partial rd_valid after release.

Reset
REQ-033 On reset_n=0, asynchronously: state=IDLE, pointers=0, fill_level=0, overflow_cnt=0, rd_valid=0, rd_data=0, available=0, complete=1.
REQ-034 Reset release SHALL be synchronous to dclk; the first state change occurs no earlier than the first edge after release.

Structure
REQ-035 Shared package qam_demap_pkg SHALL hold the state encodings (IDLE, RECEIVE, READY, READOUT) and the mode constants (MODE_DROP=0, MODE_STREAM=1).
REQ-036 Storage and pointers SHALL live in sub-module qam_sync_fifo (parameters DATA_W, DEPTH; ports push, pop, wdata, rdata, full, empty, level); the FSM and overflow logic stay in the top.

Verification (DATA_W=8, DEPTH=16, THRESH=16)
REQ-037 Reset, enable=1, push 0x00..0x0F -> state RECEIVE then READY one cycle after level=16; available=1, complete=0.
REQ-038 mode=0 in READY, 5 more in_valid -> overflow_cnt=5, fill_level stays 16; read held -> 16 rd_valid carrying 0x00..0x0F in order, then RECEIVE, complete=1.
REQ-039 mode=1, continuous push and read in READOUT -> fill_level constant, no discards, overflow_cnt=0.
REQ-040 OVF_W=2, 6 discards -> overflow_cnt=3 (saturates).
REQ-041 flush at level=9 in READOUT -> next cycle fill_level=0, overflow_cnt=0, state RECEIVE; reset_n pulse mid-readout -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/qam_demap_pkg.sv
// Shared state encodings and mode constants for the QAM demapper
// output buffer and its host-side flow control.
package qam_demap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RECEIVE = 2'b01,
        READY   = 2'b10,
        READOUT = 2'b11
    } state_t;

    localparam logic MODE_DROP   = 1'b0;
    localparam logic MODE_STREAM = 1'b1;

endpackage

// File: rtl/qam_sync_fifo.sv
// Single-clock word FIFO with an explicit fill counter so that a full
// FIFO can still accept a push when a pop happens in the same cycle.
module qam_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              dclk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);

    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       level_q;

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset; only pointers define what is valid.
    always_ff @(posedge dclk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/qam_demap_flow_ctrl.sv
// Demapper output buffer: collects symbols, signals the host when a
// block is available, and drains it on read requests.
module qam_demap_flow_ctrl
    import qam_demap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int THRESH = DEPTH,
    parameter int OVF_W  = 8
) (
    input  logic                     dclk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     flush,
    input  logic                     mode,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     read,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     available,
    output logic                     complete,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [OVF_W-1:0]         overflow_cnt,
    output logic [1:0]               state
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LVL_THR = LW'(THRESH);

    state_t            state_q;
    logic              push_ok;
    logic              push;
    logic              pop;
    logic              discard;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] fifo_rdata;

    always_comb begin
        push_ok = (state_q == RECEIVE) ||
                  (state_q[1] && mode == MODE_STREAM);
        pop     = read && (state_q == READOUT) && !empty && !flush;
        // A full FIFO still takes a symbol when a word leaves this cycle.
        push    = in_valid && push_ok && (!full || pop) && !flush;
        discard = in_valid && (state_q != IDLE) && !push && !flush;
    end

    qam_sync_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .dclk   (dclk),
        .reset_n(reset_n),
        .clear  (flush),
        .push   (push),
        .pop    (pop),
        .wdata  (in_data),
        .rdata  (fifo_rdata),
        .full   (full),
        .empty  (empty),
        .level  (fill_level)
    );

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else if (!enable) begin
            state_q <= IDLE;
        end else if (flush) begin
            state_q <= RECEIVE;
        end else begin
            case (state_q)
                IDLE:    state_q <= RECEIVE;
                RECEIVE: if (fill_level >= LVL_THR) state_q <= READY;
                READY:   if (read) state_q <= READOUT;
                READOUT: if (fill_level == '0 && !push) state_q <= RECEIVE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_cnt <= '0;
        end else if (flush) begin
            overflow_cnt <= '0;
        end else if (discard && overflow_cnt != '1) begin
            overflow_cnt <= overflow_cnt + 1'b1;
        end
    end

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= pop;
            if (pop) rd_data <= fifo_rdata;
        end
    end

    assign available = (state_q == READY) || (state_q == READOUT);
    assign complete  = (state_q == IDLE) || (state_q == RECEIVE);
    assign state     = state_q;

endmodule
